cp0_ctrl: RTL and testbench

- Coprocessor-0 controller for the MIPS core.
- Owns the CP0 architectural registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
- Services MTC0 writes and MFC0 reads, runs the Count/Compare timer, and sequences exception entry and ERET return.
- Drives pipeline flush and PC redirect. Sits beside the MEM/WB boundary, where exceptions are committed.

---
 rtl/cp0_pkg.sv | 41 ++++
 rtl/cp0_timer.sv | 57 +++++
 rtl/cp0_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cp0_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and the commit/flush sequencer state type.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LO   = 8;
  localparam int STATUS_IM_HI   = 15;
  localparam int STATUS_BEV_BIT = 22;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_TI_BIT = 30;
  localparam int CAUSE_BD_BIT = 31;

  typedef enum logic [1:0] {ST_RUN, ST_TRAP, ST_RET} cp0_state_t;

  // Only address-error exceptions carry a meaningful faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare match detection and the
// sticky timer-interrupt flag TI.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  input  logic        i_ti_clr,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  localparam logic [4:0] DIV_LAST = 5'(COUNT_DIV - 1);

  logic [4:0]  r_div;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_tick;
  logic [31:0] w_count_inc;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_div <= w_tick ? 5'd0 : r_div + 5'd1;
      // A software write to Count wins over the prescaled increment.
      if (i_count_we)
        r_count <= i_wdata;
      else if (w_tick)
        r_count <= w_count_inc;
      if (i_compare_we)
        r_compare <= i_wdata;
      if (i_ti_clr)
        r_ti <= 1'b0;
      else if (w_tick && !i_count_we && (w_count_inc == r_compare))
        r_ti <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 controller: architectural CP0 registers, MTC0/MFC0 access,
// exception entry / ERET sequencing with one-cycle flush and PC redirect.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic        int_req,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] status_o,
  output logic [31:0] epc_o
);

  cp0_state_t  r_state;
  logic        r_flush;
  logic [31:0] r_redirect;
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [4:0]  r_exccode;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_hw;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic        w_run, w_exc, w_eret, w_we;
  logic        w_ti;
  logic [31:0] w_count, w_compare;
  logic [7:0]  w_ip;
  logic [31:0] w_status, w_cause;

  // While flushing, commits and MTC0 are ignored; an exception drops a same-cycle MTC0.
  assign w_run  = (r_state == ST_RUN);
  assign w_exc  = w_run && exc_valid;
  assign w_eret = w_run && eret && !exc_valid;
  assign w_we   = w_run && we && !exc_valid;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_count_we   (w_we && (waddr == CP0_COUNT)),
    .i_compare_we (w_we && (waddr == CP0_COMPARE)),
    .i_wdata      (wdata),
    .i_ti_clr     (w_we && (waddr == CP0_COMPARE)),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  assign w_ip = {r_hw[5] | w_ti, r_hw[4:0], r_ip_sw};

  always_comb begin
    w_status = STATUS_RESET;
    w_status[STATUS_IM_HI:STATUS_IM_LO] = r_im;
    w_status[STATUS_EXL_BIT] = r_exl;
    w_status[STATUS_IE_BIT]  = r_ie;
    w_cause = '0;
    w_cause[CAUSE_BD_BIT] = r_bd;
    w_cause[CAUSE_TI_BIT] = w_ti;
    w_cause[CAUSE_IP_HI:CAUSE_IP_LO]   = w_ip;
    w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = r_exccode;
  end

  always_comb begin
    case (raddr)
      CP0_BADVADDR: rdata = r_badvaddr;
      CP0_COUNT:    rdata = w_count;
      CP0_COMPARE:  rdata = w_compare;
      CP0_STATUS:   rdata = w_status;
      CP0_CAUSE:    rdata = w_cause;
      CP0_EPC:      rdata = r_epc;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_ip_sw    <= '0;
      r_hw       <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      r_hw <= hw_int;
      if (w_we) begin
        case (waddr)
          CP0_STATUS: begin
            r_im  <= wdata[STATUS_IM_HI:STATUS_IM_LO];
            r_exl <= wdata[STATUS_EXL_BIT];
            r_ie  <= wdata[STATUS_IE_BIT];
          end
          CP0_CAUSE: r_ip_sw <= wdata[9:8];
          CP0_EPC:   r_epc   <= wdata;
          default: ;
        endcase
      end
      if (w_exc) begin
        // A nested exception keeps the original return point.
        if (!r_exl) begin
          r_epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          r_bd  <= exc_bd;
        end
        r_exccode <= exc_code;
        r_exl     <= 1'b1;
        if (is_addr_exc(exc_code))
          r_badvaddr <= exc_badvaddr;
      end
      if (w_eret)
        r_exl <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_flush    <= 1'b0;
      r_redirect <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_exc) begin
            r_state    <= ST_TRAP;
            r_flush    <= 1'b1;
            r_redirect <= EXC_VECTOR;
          end else if (w_eret) begin
            r_state    <= ST_RET;
            r_flush    <= 1'b1;
            r_redirect <= r_epc;
          end else begin
            r_flush <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign int_req     = r_ie && !r_exl && |(w_ip & r_im);
  assign flush       = r_flush;
  assign redirect_pc = r_redirect;
  assign status_o    = w_status;
  assign epc_o       = r_epc;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: directed vector table, randomized traffic against an
// architectural reference model, and hand sequences for timer and reset.
module tb_cp0_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr = '0;
  logic [31:0] rdata;
  logic [5:0]  hw_int = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_badvaddr = '0;
  logic        eret = 1'b0;
  logic        int_req, flush;
  logic [31:0] redirect_pc, status_o, epc_o;

  int n_checks = 0;
  int n_errors = 0;

  cp0_ctrl #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .hw_int(hw_int), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .int_req(int_req),
    .flush(flush), .redirect_pc(redirect_pc), .status_o(status_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state only.
  int unsigned m_cyc;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti, m_flush;
  logic [4:0]  m_code;
  logic [1:0]  m_sw;
  logic [5:0]  m_hw;
  logic [31:0] m_epc, m_badv, m_count, m_compare, m_redir;

  task automatic model_reset();
    m_cyc = 0; m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_flush = 0;
    m_code = '0; m_sw = '0; m_hw = '0; m_epc = '0; m_badv = '0;
    m_count = '0; m_compare = '0; m_redir = '0;
  endtask

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | {16'h0, m_im, 6'h0, m_exl, m_ie};
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'h0, m_ip(), 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic m_int();
    return m_ie && !m_exl && ((m_ip() & m_im) != 8'h00);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic busy, do_exc, do_eret, do_we, tick;
    logic [31:0] old_cmp;
    busy    = m_flush;
    do_exc  = !busy && exc_valid;
    do_eret = !busy && eret && !exc_valid;
    do_we   = !busy && we && !exc_valid;
    m_cyc   = m_cyc + 1;
    tick    = (m_cyc % DIV) == 0;
    old_cmp = m_compare;
    if (do_we && waddr == 5'd9) m_count = wdata;
    else if (tick) begin
      m_count = m_count + 1;
      if (m_count == old_cmp) m_ti = 1;
    end
    if (do_we && waddr == 5'd11) begin m_compare = wdata; m_ti = 0; end
    if (do_exc) begin m_flush = 1; m_redir = VEC; end
    else if (do_eret) begin m_flush = 1; m_redir = m_epc; end
    else m_flush = 0;
    m_hw = hw_int;
    if (do_we) begin
      if (waddr == 5'd12) begin m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0]; end
      if (waddr == 5'd13) m_sw = wdata[9:8];
      if (waddr == 5'd14) m_epc = wdata;
    end
    if (do_exc) begin
      if (!m_exl) begin m_epc = exc_bd ? exc_pc - 4 : exc_pc; m_bd = exc_bd; end
      m_code = exc_code;
      m_exl  = 1;
      if (exc_code == 5'd4 || exc_code == 5'd5) m_badv = exc_badvaddr;
    end
    if (do_eret) m_exl = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    chk("flush", flush, m_flush);
    if (m_flush) chk("redirect_pc", redirect_pc, m_redir);
    chk("status_o", status_o, m_status());
    chk("epc_o", epc_o, m_epc);
    chk("int_req", int_req, m_int());
    chk("rdata", rdata, m_read(raddr));
  endtask

  task automatic clear_inputs();
    we = 0; waddr = '0; wdata = '0; hw_int = '0; exc_valid = 0; exc_code = '0;
    exc_pc = '0; exc_bd = 0; exc_badvaddr = '0; eret = 0;
  endtask

  task automatic reset_checks();
    logic [4:0] regs [6];
    regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_status_o", status_o, 32'h0040_0000);
    chk("rst_epc_o", epc_o, 0);
    chk("rst_int_req", int_req, 0);
    for (int i = 0; i < 6; i++) begin
      raddr = regs[i]; #1;
      chk($sformatf("rst_reg%0d", regs[i]), rdata, (regs[i] == 5'd12) ? 32'h0040_0000 : 32'h0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  hw;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] badv;
    logic        eret;
    logic [4:0]  raddr;
    logic        e_flush;
    logic [31:0] e_redir;
    logic        e_int;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t v(input logic w, input logic [4:0] wa, input logic [31:0] wd,
      input logic [5:0] hw, input logic x, input logic [4:0] c, input logic [31:0] pc,
      input logic bd, input logic [31:0] ba, input logic er, input logic [4:0] ra,
      input logic ef, input logic [31:0] erd, input logic ei, input logic [31:0] ed);
    vec_t t;
    t.we = w; t.waddr = wa; t.wdata = wd; t.hw = hw; t.exc = x; t.code = c; t.pc = pc;
    t.bd = bd; t.badv = ba; t.eret = er; t.raddr = ra;
    t.e_flush = ef; t.e_redir = erd; t.e_int = ei; t.e_rdata = ed;
    return t;
  endfunction

  vec_t tbl [29];

  initial begin
    int n, seen;
    logic [4:0] wl [8];
    logic [4:0] cl [7];
    wl = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd30};
    cl = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

    //           we wa  wdata          hw     x  c   pc             bd badv           er ra  ef redir          int rdata
    tbl[0]  = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 12, 0, 0,             0, 32'h0040_0000);
    tbl[1]  = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 13, 0, 0,             0, 0);
    tbl[2]  = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 14, 0, 0,             0, 0);
    tbl[3]  = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 8,  0, 0,             0, 0);
    tbl[4]  = v(1, 12, 32'h0000_8001, 0,     0, 0,  0,             0, 0,             0, 12, 0, 0,             0, 32'h0040_8001);
    tbl[5]  = v(0, 0,  0,             6'h20, 0, 0,  0,             0, 0,             0, 13, 0, 0,             1, 32'h0000_8000);
    tbl[6]  = v(1, 12, 32'h0000_8003, 6'h20, 0, 0,  0,             0, 0,             0, 12, 0, 0,             0, 32'h0040_8003);
    tbl[7]  = v(1, 12, 32'h0000_8001, 0,     0, 0,  0,             0, 0,             0, 13, 0, 0,             0, 0);
    tbl[8]  = v(0, 0,  0,             0,     1, 8,  32'h8000_0010, 1, 0,             0, 14, 1, VEC,           0, 32'h8000_000C);
    tbl[9]  = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 13, 0, 0,             0, 32'h8000_0020);
    tbl[10] = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 12, 0, 0,             0, 32'h0040_8003);
    tbl[11] = v(1, 14, 32'h8000_0040, 0,     0, 0,  0,             0, 0,             0, 14, 0, 0,             0, 32'h8000_0040);
    tbl[12] = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             1, 12, 1, 32'h8000_0040, 0, 32'h0040_8001);
    tbl[13] = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 12, 0, 0,             0, 32'h0040_8001);
    tbl[14] = v(0, 0,  0,             0,     1, 10, 32'h8000_0100, 0, 0,             1, 14, 1, VEC,           0, 32'h8000_0100);
    tbl[15] = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 13, 0, 0,             0, 32'h0000_0028);
    tbl[16] = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             1, 12, 1, 32'h8000_0100, 0, 32'h0040_8001);
    tbl[17] = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 12, 0, 0,             0, 32'h0040_8001);
    tbl[18] = v(0, 0,  0,             0,     1, 4,  32'h8000_0200, 0, 32'h1234_5679, 0, 8,  1, VEC,           0, 32'h1234_5679);
    tbl[19] = v(1, 14, 32'hDEAD_BEEF, 0,     0, 0,  0,             0, 0,             0, 14, 0, 0,             0, 32'h8000_0200);
    tbl[20] = v(0, 0,  0,             0,     1, 5,  32'h8000_0300, 1, 32'hAAAA_0001, 0, 14, 1, VEC,           0, 32'h8000_0200);
    tbl[21] = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 13, 0, 0,             0, 32'h0000_0014);
    tbl[22] = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 8,  0, 0,             0, 32'hAAAA_0001);
    tbl[23] = v(1, 12, 0,             0,     1, 12, 32'h8000_0400, 0, 0,             0, 12, 1, VEC,           0, 32'h0040_8003);
    tbl[24] = v(1, 12, 32'hFFFF_FFFF, 0,     0, 0,  0,             0, 0,             0, 12, 0, 0,             0, 32'h0040_8003);
    tbl[25] = v(1, 12, 32'hFFFF_FFFF, 0,     0, 0,  0,             0, 0,             1, 12, 1, 32'h8000_0200, 0, 32'h0040_FF01);
    tbl[26] = v(0, 0,  0,             0,     0, 0,  0,             0, 0,             0, 12, 0, 0,             0, 32'h0040_FF01);
    tbl[27] = v(1, 13, 32'h0000_0300, 0,     0, 0,  0,             0, 0,             0, 13, 0, 0,             1, 32'h0000_0330);
    tbl[28] = v(1, 12, 0,             0,     0, 0,  0,             0, 0,             0, 12, 0, 0,             0, 32'h0040_0000);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    rst = 0;

    for (int i = 0; i < 29; i++) begin
      we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata; hw_int = tbl[i].hw;
      exc_valid = tbl[i].exc; exc_code = tbl[i].code; exc_pc = tbl[i].pc; exc_bd = tbl[i].bd;
      exc_badvaddr = tbl[i].badv; eret = tbl[i].eret; raddr = tbl[i].raddr;
      step();
      chk($sformatf("vec%0d_flush", i), flush, tbl[i].e_flush);
      if (tbl[i].e_flush) chk($sformatf("vec%0d_redirect", i), redirect_pc, tbl[i].e_redir);
      chk($sformatf("vec%0d_int_req", i), int_req, tbl[i].e_int);
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
      $display("vec %0d: raddr=%0d rdata=%08h flush=%0b redirect=%08h int_req=%0b",
               i, raddr, rdata, flush, redirect_pc, int_req);
    end
    clear_inputs();

    // Same-cycle MTC0/MFC0 to EPC returns the old value.
    raddr = 5'd14; we = 1; waddr = 5'd14; wdata = 32'h1234_0000; #1;
    chk("no_bypass", rdata, m_epc);
    step();
    clear_inputs();

    // Timer: Compare=5, Count=0 -> TI after five prescaled ticks.
    we = 1; waddr = 5'd11; wdata = 32'd5; step();
    waddr = 5'd9; wdata = 32'd0; step();
    we = 0; raddr = 5'd13;
    n = 0; seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      step();
      n++;
      if (rdata[30]) seen = 1;
    end
    chk("ti_seen", seen, 1);
    chk("ti_latency_ok", (n == 9 || n == 10), 1);
    raddr = 5'd9; #1;
    chk("ti_count", rdata, 32'd5);
    we = 1; waddr = 5'd11; wdata = 32'd100; raddr = 5'd13; step();
    chk("ti_cleared", rdata[30], 0);
    waddr = 5'd9; wdata = 32'hFFFF_FFFF; raddr = 5'd9; step();
    we = 0;
    for (int k = 0; k < 4 && rdata == 32'hFFFF_FFFF; k++) step();
    chk("count_wrap", rdata, 32'd0);
    $display("timer: TI after %0d cycles, Count wrapped to %08h", n, rdata);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      we = ($urandom_range(0, 3) == 0);
      waddr = wl[$urandom_range(0, 7)];
      wdata = $urandom;
      if (waddr == 5'd9) wdata = $urandom_range(0, 1) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 50);
      if (waddr == 5'd11) wdata = m_count + $urandom_range(1, 8);
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
      exc_valid = ($urandom_range(0, 15) == 0);
      exc_code = cl[$urandom_range(0, 6)];
      exc_pc = {$urandom, 2'b00} >> 2 << 2;
      exc_bd = 1'($urandom);
      exc_badvaddr = $urandom;
      eret = ($urandom_range(0, 11) == 0);
      raddr = 5'($urandom_range(0, 15));
      step();
    end
    $display("random: %0d cycles applied", 1500);
    clear_inputs();

    // Asynchronous reset while flushing into the exception vector.
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h8000_0800;
    step();
    clear_inputs();
    #2 rst = 1;
    #1;
    model_reset();
    reset_checks();
    @(posedge clk); #1;
    rst = 0;
    raddr = 5'd12;
    step();
    $display("reset: mid-trap reset checked");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
